// File: rtl/usr_pkg.sv
// Shared definitions for the usr serial link (receiver today, transmitter later).
package usr_pkg;

   typedef enum logic [0:0] {
      USR_IDLE = 1'b0,
      USR_RECV = 1'b1
   } usr_state_e;

   localparam logic USR_MSB_FIRST = 1'b0;
   localparam logic USR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/usr_deser_shreg.sv
// Shift register, bit-order mux and bit counter for the usr receiver.
// o_word is the value the register takes on a shift, so the top can capture it on the completing edge.
module usr_deser_shreg
   import usr_pkg::*;
#(
   parameter int data_bitsize = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    i_start,
   input  logic                    i_shift,
   input  logic                    i_sin,
   input  logic                    i_order,
   output logic [data_bitsize-1:0] o_word,
   output logic                    o_word_done
);

   localparam int CW = $clog2(data_bitsize + 1);

   logic [data_bitsize-1:0] r_shreg;
   logic [CW-1:0]           r_cnt;
   logic [data_bitsize-1:0] w_shifted;
   logic [data_bitsize-1:0] w_first;
   logic [CW-1:0]           w_cnt_inc;

   // A fresh word starts from a clean register so stale bits never leak into it.
   assign w_shifted = (i_order == USR_LSB_FIRST) ? {i_sin, r_shreg[data_bitsize-1:1]}
                                                 : {r_shreg[data_bitsize-2:0], i_sin};
   assign w_first   = (i_order == USR_LSB_FIRST) ? {i_sin, {(data_bitsize-1){1'b0}}}
                                                 : {{(data_bitsize-1){1'b0}}, i_sin};
   assign w_cnt_inc = r_cnt + CW'(1);

   assign o_word      = w_shifted;
   assign o_word_done = i_shift && (w_cnt_inc == CW'(data_bitsize));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shreg <= '0;
         r_cnt   <= '0;
      end else if (i_start) begin
         r_shreg <= w_first;
         r_cnt   <= CW'(1);
      end else if (i_shift) begin
         r_shreg <= w_shifted;
         r_cnt   <= o_word_done ? '0 : w_cnt_inc;
      end
   end

endmodule

// File: rtl/usr_deser.sv
// Serial-to-parallel receiver: frame FSM, one-deep output holding register with
// valid/ready handshake, and sticky overrun / framing error flags.
module usr_deser
   import usr_pkg::*;
#(
   parameter int data_bitsize = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    sin,
   input  logic                    sin_valid,
   input  logic                    frame_start,
   input  logic                    lsb_first,
   input  logic                    dout_ready,
   input  logic                    clr_err,
   output logic [data_bitsize-1:0] dout,
   output logic                    dout_valid,
   output logic                    overrun,
   output logic                    frame_err
);

   usr_state_e              r_state, w_state_nxt;
   logic                    r_lsb;
   logic [data_bitsize-1:0] r_dout;
   logic                    r_dout_valid;
   logic                    r_overrun;
   logic                    r_frame_err;

   logic                    w_start;
   logic                    w_shift;
   logic                    w_order;
   logic [data_bitsize-1:0] w_word;
   logic                    w_done;
   logic                    w_accept;
   logic                    w_load;
   logic                    w_ovr_ev;
   logic                    w_ferr_ev;

   // frame_start restarts the word in either state, using the freshly presented bit order.
   assign w_start = sin_valid && frame_start;
   assign w_shift = sin_valid && !frame_start && (r_state == USR_RECV);
   assign w_order = w_start ? lsb_first : r_lsb;

   usr_deser_shreg #(
      .data_bitsize (data_bitsize)
   ) u_shreg (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_start     (w_start),
      .i_shift     (w_shift),
      .i_sin       (sin),
      .i_order     (w_order),
      .o_word      (w_word),
      .o_word_done (w_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= USR_IDLE;
         r_lsb   <= USR_MSB_FIRST;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) r_lsb <= lsb_first;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ferr_ev   = 1'b0;
      case (r_state)
         USR_IDLE: begin
            if (w_start) w_state_nxt = USR_RECV;
         end
         USR_RECV: begin
            if (w_start) begin
               w_ferr_ev = 1'b1;
            end else if (w_done) begin
               w_state_nxt = USR_IDLE;
            end
         end
         default: w_state_nxt = USR_IDLE;
      endcase
   end

   // A word may load on the same edge the previous one drains.
   assign w_accept = r_dout_valid && dout_ready;
   assign w_load   = w_done && (!r_dout_valid || dout_ready);
   assign w_ovr_ev = w_done && r_dout_valid && !dout_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_overrun    <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         if (w_load) begin
            r_dout       <= w_word;
            r_dout_valid <= 1'b1;
         end else if (w_accept) begin
            r_dout_valid <= 1'b0;
         end
         r_overrun   <= w_ovr_ev  || (r_overrun   && !clr_err);
         r_frame_err <= w_ferr_ev || (r_frame_err && !clr_err);
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign overrun    = r_overrun;
   assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_usr_deser.sv
// Randomised scoreboard bench for usr_deser: a bit-list reference model predicts words and flags.
module tb_usr_deser;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         sin = 1'b0, sin_valid = 1'b0, frame_start = 1'b0, lsb_first = 1'b0;
   logic         dout_ready = 1'b0, clr_err = 1'b0;
   logic [N-1:0] dout;
   logic         dout_valid, overrun, frame_err;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: received bits of the current word, plus holding-register and flag state
   bit           m_bits[$];
   bit           m_lsb;
   bit           m_full, m_ovr, m_ferr;
   logic [N-1:0] exp_q[$];

   usr_deser #(.data_bitsize(N)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sin         (sin),
      .sin_valid   (sin_valid),
      .frame_start (frame_start),
      .lsb_first   (lsb_first),
      .dout_ready  (dout_ready),
      .clr_err     (clr_err),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .overrun     (overrun),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] assemble();
      logic [N-1:0] w = '0;
      for (int i = 0; i < N; i++) begin
         if (m_lsb) w[i] = m_bits[i];
         else       w[N-1-i] = m_bits[i];
      end
      return w;
   endfunction

   // Drive one cycle of inputs, advance the model to the coming edge, then check after that edge.
   task automatic cyc(input bit v, input bit fs, input bit s, input bit lsb, input bit rdy, input bit clr);
      bit done = 0, ev_ovr = 0, ev_ferr = 0;
      logic [N-1:0] w = '0;
      sin_valid = v; frame_start = fs; sin = s; lsb_first = lsb; dout_ready = rdy; clr_err = clr;
      if (v) begin
         if (fs) begin
            if (m_bits.size() > 0) ev_ferr = 1;
            m_bits.delete();
            m_bits.push_back(s);
            m_lsb = lsb;
         end else if (m_bits.size() > 0) begin
            m_bits.push_back(s);
            if (m_bits.size() == N) begin
               w = assemble();
               done = 1;
               m_bits.delete();
            end
         end
      end
      if (done) begin
         if (!m_full || rdy) begin
            exp_q.push_back(w);
            m_full = 1;
         end else begin
            ev_ovr = 1;
         end
      end else if (m_full && rdy) begin
         m_full = 0;
      end
      m_ovr  = ev_ovr  || (m_ovr  && !clr);
      m_ferr = ev_ferr || (m_ferr && !clr);
      @(posedge clk);
      #1;
      chk("dout_valid", dout_valid, m_full);
      chk("overrun", overrun, m_ovr);
      chk("frame_err", frame_err, m_ferr);
   endtask

   task automatic send(input logic [N-1:0] seq, input bit lsb, input bit rdy, input bit rdy_last, input int gap);
      for (int i = N-1; i >= 0; i--) begin
         cyc(1, i == N-1, seq[i], lsb, (i == 0) ? rdy_last : rdy, 0);
         if (i > 0) repeat (gap) cyc(0, 0, 0, lsb, rdy, 0);
      end
   endtask

   task automatic expect_word(input string name, input logic [N-1:0] val);
      chk(name, dout, val);
      chk({name, " valid"}, dout_valid, 1);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      sin_valid = 0; frame_start = 0; sin = 0; lsb_first = 0; dout_ready = 0; clr_err = 0;
      #2;
      chk("rst dout", dout, 0);
      chk("rst dout_valid", dout_valid, 0);
      chk("rst overrun", overrun, 0);
      chk("rst frame_err", frame_err, 0);
      m_bits.delete(); exp_q.delete();
      m_full = 0; m_ovr = 0; m_ferr = 0; m_lsb = 0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // monitor: every word the consumer takes must be the next one the model predicted
   always @(negedge clk) begin
      if (reset_n && dout_valid && dout_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got word %0h but none expected at %0t", dout, $time);
         end else begin
            chk("dout word", dout, exp_q.pop_front());
         end
      end
   end

   initial begin
      #12;
      do_reset();

      send(4'b1011, 0, 0, 0, 0);
      expect_word("msb first", 4'b1011);
      cyc(0, 0, 0, 0, 1, 0);

      send(4'b1011, 1, 0, 0, 3);
      expect_word("lsb first gapped", 4'b1101);
      cyc(0, 0, 0, 0, 1, 0);

      send(4'b1011, 0, 0, 0, 0);
      send(4'b0110, 0, 0, 0, 0);
      expect_word("backpressure hold", 4'b1011);
      chk("backpressure overrun", overrun, 1);
      cyc(0, 0, 0, 0, 1, 0);
      chk("drain valid", dout_valid, 0);
      cyc(0, 0, 0, 0, 0, 1);
      chk("clr overrun", overrun, 0);

      send(4'b1011, 0, 0, 0, 0);
      send(4'b0011, 0, 0, 1, 0);
      expect_word("drain and load", 4'b0011);
      chk("drain and load overrun", overrun, 0);
      cyc(0, 0, 0, 0, 1, 0);

      cyc(1, 1, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      send(4'b1100, 0, 0, 0, 0);
      chk("resync frame_err", frame_err, 1);
      expect_word("resync word", 4'b1100);
      cyc(0, 0, 0, 0, 1, 1);

      cyc(1, 1, 1, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 0);
      do_reset();
      send(4'b1011, 0, 0, 0, 0);
      expect_word("after reset", 4'b1011);
      cyc(0, 0, 0, 0, 1, 0);

      for (int i = 0; i < 600; i++) begin
         bit v;
         v = ($urandom_range(0, 9) < 7);
         cyc(v, v && ($urandom_range(0, 9) < 2), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
      end

      repeat (3) cyc(0, 0, 0, 0, 1, 1);
      chk("scoreboard drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/usr_deser.md
# usr_deser

Serial-to-parallel receiver that collects the serial bit stream produced by the team's universal shift register (`usr`) running in shift mode and rebuilds parallel words. Supports MSB-first and LSB-first framing, gapped bit strobes and frame resynchronisation. Presents each completed word through a one-deep output holding register with a valid/ready handshake. Sits at the receive end of the serial link, between the pin-side bit sampler and the parallel consumer.

## Interface
- `data_bitsize`, default 4: word width in bits; legal range is 2 or more.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sin`  in  1  serial data bit; sampled only when `sin_valid`=1.
- `sin_valid`  in  1  bit strobe; one bit is consumed per cycle in which it is high.
- `frame_start`  in  1  marks the current `sin_valid` bit as bit 0 of a new word; ignored when `sin_valid`=0.
- `lsb_first`  in  1  bit order: 0 = MSB-first, 1 = LSB-first; latched on `frame_start`.
- `dout_ready`  in  1  consumer accepts `dout` in any cycle where `dout_valid` and `dout_ready` are both high.
- `clr_err`  in  1  synchronous clear of the sticky error flags.
- `dout`  out  `data_bitsize`  assembled word; resets to 0 and holds while `dout_valid`=1.
- `dout_valid`  out  1  holding register full; resets to 0.
- `overrun`  out  1  sticky; a completed word was dropped; resets to 0.
- `frame_err`  out  1  sticky; `frame_start` arrived mid-word; resets to 0.

## Operation
- FSM states: IDLE and RECV. The reset state is IDLE.
- IDLE: bits with `frame_start`=0 are discarded. `sin_valid`=1 with `frame_start`=1 loads bit 0, latches `lsb_first`, sets bit count to 1 and moves to RECV.
- RECV, `sin_valid`=1 and `frame_start`=0: shift in one bit and increment the count.
  - MSB-first: `shreg <= {shreg[N-2:0], sin}`.
  - LSB-first: `shreg <= {sin, shreg[N-1:1]}`.
- RECV, `sin_valid`=0: hold all state. Gaps of any length are legal.
- Word completion: the bit that brings the count to `data_bitsize` completes the word. The FSM returns to IDLE.
  - If the holding register is empty, or is being drained in the same cycle (`dout_valid`&`dout_ready`), the finished word is loaded into `dout` and `dout_valid`=1.
  - Otherwise the new word is dropped, `dout` keeps the old word and `overrun` is set.
- `frame_start` in RECV: the partial word is discarded, `frame_err` is set, and the current bit restarts as bit 0 of a new word with `lsb_first` re-latched. The FSM stays in RECV.
- `data_bitsize` equal to 1 is not supported.
- Handshake: `dout_valid` falls after an accepting edge unless a new word loads on that same edge, in which case it stays high with the new data. `dout` is stable while valid and not accepted.
- `clr_err` clears both flags. If an error event occurs in the same cycle, the event wins and the flag stays set.
- Bit counter width is `$clog2(data_bitsize+1)`. The counter never wraps because completion resets it.
- Reset asserted mid-word: everything clears asynchronously; the partial word is lost.

## Timing
- The last bit is sampled on edge k. `dout`/`dout_valid` are visible right after edge k, so latency is 1 clock from the last `sin_valid` cycle.
- Minimum word period is `data_bitsize` cycles, with `frame_start` on the first bit of each word. Back-to-back words need no idle cycle.
- Outputs are registered. There is no combinational path from inputs to outputs.
- `reset_n` deassertion is synchronised by the system; the block needs no internal synchroniser.

## Structure
- Shared package `usr_pkg`: FSM state enum (`USR_IDLE`, `USR_RECV`) and bit-order constants `USR_MSB_FIRST`=0 and `USR_LSB_FIRST`=1. The future transmitter imports the same package.
- One natural sub-module, `usr_deser_shreg`. It contains the shift register, the bit-order mux and the bit counter, and produces a `word_done` pulse.
- The top level holds the FSM, the holding register, the handshake and the error flags.

## Test plan
- MSB-first, `data_bitsize`=4: bits 1,0,1,1 on consecutive cycles with `frame_start` on the first → `dout`=4'b1011 and `dout_valid`=1 one edge after the 4th bit.
- LSB-first, same bits 1,0,1,1 → `dout`=4'b1101. Gaps of 3 idle cycles between bits produce the same result.
- Backpressure: `dout_ready`=0 and two full words 1011 then 0110 → `dout` stays 1011 and `overrun`=1. Raise `dout_ready` → `dout_valid` drops; `clr_err` clears `overrun`.
- Simultaneous drain and load: the word 0011 completes on the same edge that 1011 is accepted → `dout`=0011, `dout_valid` stays 1, `overrun`=0.
- Resync: `frame_start` after 2 bits, then 1,1,0,0 → `frame_err`=1 and `dout`=4'b1100.
- Reset mid-word: `reset_n` low after 2 bits → all outputs 0 and FSM in IDLE. A new word then 1,0,1,1 → `dout`=1011.
